// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART console transmitter:
// address map, store-type and TX-state enums, and the status-word layout.
package uart_tx_mmio_pkg;

  // Console devices share the store bus. The UART window sits beside stdout.
  localparam logic [63:0] STDOUT_BASE_ADDR = 64'h0000_0000_1000_0000;
  localparam logic [63:0] UART_BASE_ADDR   = 64'h0000_0000_1000_0010;
  localparam logic [63:0] UART_WIN_BYTES   = 64'd8;

  typedef enum logic [1:0] {
    NO_STORE,
    STORE_BYTE,
    STORE_WORD,
    STORE_DWORD
  } mem_store_type_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Status dword seen by software: bit4 overflow, bit3 empty, bit2 full, bit1 busy.
  function automatic logic [63:0] pack_status(input logic ovf, input logic empty,
                                              input logic full, input logic busy);
    return {59'b0, ovf, empty, full, busy, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == (PW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  // Storage array; no reset needed, validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wptr] <= din;
  end

  // Pointers wrap naturally; count follows net push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped console transmitter: bytes stored to the UART window are
// queued and sent as 8N1 frames on tx. A load or store in the window returns
// the status dword. Define UART_SIM_PRINT_EN to echo each sent byte to the
// simulator log.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [63:0]     addr,
  input  mem_store_type_t mem_store_type,
  input  logic [63:0]     w_data,
  output logic [63:0]     r_data,
  output logic            uart_taken,
  output logic            tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift;
  logic          r_ovf;
  logic          r_taken;

  logic          w_hit, w_store, w_clr, w_push, w_pop;
  logic          w_full, w_empty, w_busy, w_bit_end, w_tx;
  logic [7:0]    w_head;
  logic [PW:0]   w_count;

  assign w_hit   = enable & (addr >= UART_BASE_ADDR) & (addr < UART_BASE_ADDR + UART_WIN_BYTES);
  assign w_store = w_hit & (mem_store_type != NO_STORE);
  assign w_clr   = w_store & w_data[8];
  assign w_push  = w_store & ~w_data[8];
  assign w_busy  = (r_state != IDLE) | ~w_empty;

  assign r_data     = w_hit ? pack_status(r_ovf, w_empty, w_full, w_busy) : '0;
  assign uart_taken = r_taken;
  assign tx         = w_tx;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_data[7:0]),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_bit_end = (r_cnt == C_LAST);

  // Next-state, counters and line level; tx is decoded from state so reset forces it high at once.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx = 1'b0;
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        w_tx = r_shift[r_idx];
        if (w_bit_end) begin
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, bit timing and the shift register loaded from the FIFO head on pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pop) r_shift <= w_head;
    end
  end

  // Sticky overflow: a clear store wins; a push into a full FIFO with no pop sets it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             r_ovf <= 1'b0;
    else if (w_clr)                        r_ovf <= 1'b0;
    else if (w_push & w_full & ~w_pop)     r_ovf <= 1'b1;
  end

  // Access acknowledge, one cycle after any in-window access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_taken <= 1'b0;
    else       r_taken <= w_hit;
  end

`ifdef UART_SIM_PRINT_EN
  // Echo each byte as it leaves the FIFO.
  always_ff @(posedge clock) begin
    if (!reset && w_pop) $write("%c", w_head);
  end
`endif

  wire w_unused = &{1'b0, w_data[63:9], w_count};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A background serial decoder collects transmitted bytes into rx_q.
module tb_uart_tx_mmio;
  import uart_tx_mmio_pkg::*;

  logic            clock;
  logic            reset;
  logic            enable;
  logic [63:0]     addr;
  mem_store_type_t mem_store_type;
  logic [63:0]     w_data;
  logic [63:0]     r_data;
  logic            uart_taken;
  logic            tx;

  int n_cmp = 0;
  int n_err = 0;
  int rx_bad = 0;
  logic       rx_en;
  logic [7:0] rx_q [$];

  uart_tx_mmio #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .addr           (addr),
    .mem_store_type (mem_store_type),
    .w_data         (w_data),
    .r_data         (r_data),
    .uart_taken     (uart_taken),
    .tx             (tx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Serial decoder: samples each bit at cycle 2 of its 4-cycle period on the falling clock.
  initial begin : rx_dec
    logic [7:0] d;
    d = '0;
    forever begin
      @(negedge clock);
      if (rx_en && !reset && tx === 1'b0) begin
        repeat (2) @(negedge clock);
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clock);
          d[b] = tx;
        end
        repeat (4) @(negedge clock);
        if (tx !== 1'b1) rx_bad++;
        rx_q.push_back(d);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    enable = 1'b0; addr = '0; mem_store_type = NO_STORE; w_data = '0;
  endtask

  task automatic bus_load();
    enable = 1'b1; addr = UART_BASE_ADDR; mem_store_type = NO_STORE; w_data = '0;
  endtask

  task automatic store(input logic [63:0] a, input mem_store_type_t t, input logic [63:0] d);
    enable = 1'b1; addr = a; mem_store_type = t; w_data = d;
    tick();
    idle_bus();
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_en = 1'b0; idle_bus();
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_cmp++; if (uart_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b expected 0", uart_taken); end
    n_cmp++; if (r_data !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", r_data); end
    reset = 1'b0;
    tick();
    bus_load(); #1;
    n_cmp++; if (r_data !== 64'h8) begin n_err++; $display("FAIL reset_status: got %h expected 8", r_data); end
    tick(); idle_bus();
    n_cmp++; if (uart_taken !== 1'b1) begin n_err++; $display("FAIL load_taken: got %b expected 1", uart_taken); end
    tick();
    n_cmp++; if (uart_taken !== 1'b0) begin n_err++; $display("FAIL taken_pulse: got %b expected 0", uart_taken); end
    rx_en = 1'b1;
  endtask

  task automatic test_store_byte();
    logic [9:0] pat;
    logic [7:0] got;
    bit ok;
    pat = {1'b1, 8'h41, 1'b0};
    store(UART_BASE_ADDR + 64'd7, STORE_BYTE, 64'h41);
    n_cmp++; if (uart_taken !== 1'b1) begin n_err++; $display("FAIL sb_taken: got %b expected 1", uart_taken); end
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL sb_tx_before_pop: got %b expected 1", tx); end
    tick();
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL sb_tx_start_edge: got %b expected 0", tx); end
    n_cmp++; if (uart_taken !== 1'b0) begin n_err++; $display("FAIL sb_taken_drop: got %b expected 0", uart_taken); end
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (tx !== pat[b]) ok = 1'b0;
        tick();
      end
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL sb_frame_bit%0d: got %b expected %b", b, tx, pat[b]); end
    end
    bus_load(); #1;
    n_cmp++; if (r_data !== 64'h8) begin n_err++; $display("FAIL sb_idle_status: got %h expected 8", r_data); end
    tick(); idle_bus();
    wait_rx(1, 10, ok);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    n_cmp++; if (got !== 8'h41) begin n_err++; $display("FAIL sb_rx: got %h expected 41", got); end
  endtask

  task automatic test_store_dword();
    logic [7:0] got;
    bit ok;
    store(UART_BASE_ADDR, STORE_DWORD, 64'hDEAD_BEEF_0000_1234);
    wait_rx(1, 100, ok);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    n_cmp++; if (got !== 8'h34) begin n_err++; $display("FAIL dw_rx: got %h expected 34", got); end
    repeat (60) tick();
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL dw_extra: got %0d bytes expected 0", rx_q.size()); end
    bus_load(); #1;
    n_cmp++; if (r_data !== 64'h8) begin n_err++; $display("FAIL dw_status: got %h expected 8", r_data); end
    tick(); idle_bus();
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    bit ok;
    for (int i = 0; i < 6; i++) store(UART_BASE_ADDR + 64'(i), STORE_BYTE, 64'(8'h30 + i));
    bus_load(); #1;
    n_cmp++; if (r_data !== 64'h16) begin n_err++; $display("FAIL b2b_status: got %h expected 16", r_data); end
    tick(); idle_bus();
    wait_rx(5, 5 * 41 + 60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got %0d bytes expected 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      n_cmp++;
      if (got !== 8'(8'h30 + i)) begin n_err++; $display("FAIL b2b_rx%0d: got %h expected %h", i, got, 8'(8'h30 + i)); end
    end
    repeat (60) tick();
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL b2b_extra: got %0d bytes expected 0", rx_q.size()); end
    bus_load(); #1;
    n_cmp++; if (r_data !== 64'h18) begin n_err++; $display("FAIL b2b_sticky_ovf: got %h expected 18", r_data); end
    tick(); idle_bus();
  endtask

  task automatic test_overflow_clear();
    logic [7:0] got;
    bit ok;
    store(UART_BASE_ADDR, STORE_BYTE, 64'h55);
    store(UART_BASE_ADDR, STORE_BYTE, 64'h56);
    store(UART_BASE_ADDR, STORE_WORD, 64'h1AA);
    bus_load(); #1;
    n_cmp++; if (r_data !== 64'h2) begin n_err++; $display("FAIL clr_status_busy: got %h expected 2", r_data); end
    tick(); idle_bus();
    wait_rx(2, 2 * 41 + 60, ok);
    for (int i = 0; i < 2; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      n_cmp++;
      if (got !== 8'(8'h55 + i)) begin n_err++; $display("FAIL clr_rx%0d: got %h expected %h", i, got, 8'(8'h55 + i)); end
    end
    repeat (60) tick();
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL clr_extra: got %0d bytes expected 0", rx_q.size()); end
    store(UART_BASE_ADDR + 64'd3, STORE_BYTE, 64'h100);
    bus_load(); #1;
    n_cmp++; if (r_data !== 64'h8) begin n_err++; $display("FAIL clr_idle_status: got %h expected 8", r_data); end
    tick(); idle_bus();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    rx_en = 1'b0;
    store(UART_BASE_ADDR, STORE_BYTE, 64'h41);
    store(UART_BASE_ADDR, STORE_BYTE, 64'h77);
    repeat (16) tick();
    bus_load();
    tick(); idle_bus();
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rst_bit3_level: got %b expected 0", tx); end
    n_cmp++; if (uart_taken !== 1'b1) begin n_err++; $display("FAIL rst_pre_taken: got %b expected 1", uart_taken); end
    reset = 1'b1;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rst_async_tx: got %b expected 1", tx); end
    n_cmp++; if (uart_taken !== 1'b0) begin n_err++; $display("FAIL rst_async_taken: got %b expected 0", uart_taken); end
    repeat (3) tick();
    reset = 1'b0;
    tick();
    bus_load(); #1;
    n_cmp++; if (r_data !== 64'h8) begin n_err++; $display("FAIL rst_status: got %h expected 8", r_data); end
    tick(); idle_bus();
    ok = 1'b1;
    repeat (60) begin
      if (tx !== 1'b1) ok = 1'b0;
      tick();
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_residual: got tx low expected idle high"); end
    rx_q.delete();
    rx_en = 1'b1;
  endtask

  task automatic test_window();
    bit ok;
    enable = 1'b1; addr = UART_BASE_ADDR + 64'd8; mem_store_type = STORE_BYTE; w_data = 64'h42;
    #1;
    n_cmp++; if (r_data !== 64'h0) begin n_err++; $display("FAIL win_hi_rdata: got %h expected 0", r_data); end
    tick(); idle_bus();
    n_cmp++; if (uart_taken !== 1'b0) begin n_err++; $display("FAIL win_hi_taken: got %b expected 0", uart_taken); end
    enable = 1'b1; addr = UART_BASE_ADDR - 64'd1; mem_store_type = STORE_DWORD; w_data = 64'h44;
    #1;
    n_cmp++; if (r_data !== 64'h0) begin n_err++; $display("FAIL win_lo_rdata: got %h expected 0", r_data); end
    tick(); idle_bus();
    n_cmp++; if (uart_taken !== 1'b0) begin n_err++; $display("FAIL win_lo_taken: got %b expected 0", uart_taken); end
    enable = 1'b0; addr = UART_BASE_ADDR; mem_store_type = STORE_BYTE; w_data = 64'h43;
    #1;
    n_cmp++; if (r_data !== 64'h0) begin n_err++; $display("FAIL win_en0_rdata: got %h expected 0", r_data); end
    tick(); idle_bus();
    n_cmp++; if (uart_taken !== 1'b0) begin n_err++; $display("FAIL win_en0_taken: got %b expected 0", uart_taken); end
    ok = 1'b1;
    repeat (60) begin
      if (tx !== 1'b1) ok = 1'b0;
      tick();
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL win_tx_quiet: got tx low expected idle high"); end
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL win_rx: got %0d bytes expected 0", rx_q.size()); end
    bus_load(); #1;
    n_cmp++; if (r_data !== 64'h8) begin n_err++; $display("FAIL win_status: got %h expected 8", r_data); end
    tick(); idle_bus();
    n_cmp++; if (rx_bad != 0) begin n_err++; $display("FAIL stop_bits: got %0d bad frames expected 0", rx_bad); end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_dword();
    test_back_to_back();
    test_overflow_clear();
    test_reset_mid_frame();
    test_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
